r2pv_128x26: RTL and testbench
==============================

# r2pv_128x26

Two-port (1 read, 1 write) synchronous SRAM macro model, 128 words × 26 bits, with a registered read port A and a bit-masked write port B. It sits under the ASIC branch of the dual-port BRAM wrapper as the tag-array storage. The 128x64 and 256x26 variants are the same RTL with different parameters.

## Interface
- WORDS, 128, number of words (power of two, ≥8); 256 for the 256x26 variant
- DATA_WIDTH, 26, word width; 64 for the 128x64 variant
- AW_WIDTH, log2(WORDS)-2, row-address width (derived, not overridden)
- CLK  in  1  single clock; both ports are clocked by it (one clock)
- RST  in  1  reset, synchronous, active-high
- CEN_A  in  1  read enable, active-high
- AW_A / AC_A  in  AW_WIDTH / 2  read address; word index = {AW_A, AC_A}
- Q  out  DATA_WIDTH  read data
- CEN_B  in  1  write enable, active-high
- AW_B / AC_B  in  AW_WIDTH / 2  write address; word index = {AW_B, AC_B}
- D  in  DATA_WIDTH  write data
- BW  in  DATA_WIDTH  per-bit write mask, 1 = write
- T_LOGIC  in  1  logic-test bypass
- POWERGATE  in  1  power-gate; array contents lost
- DEEPSLEEP  in  1  retention sleep
- MA_SAWL, MA_TPA, MA_TPB, MA_WL, MA_WRAS, MA_WRASD  in  1 each  margin adjust; no functional effect
- OBSV_DBW  out  DATA_WIDTH  registered effective write mask
- OBSV_CTL_A  out  2  registered {MA_TPA, CEN_A}
- OBSV_CTL_B  out  2  registered {MA_TPB, CEN_B}

## Operation
- Write: CEN_B=1, idle: mem[{AW_B,AC_B}][i] <= D[i] for every bit i with BW[i]=1; other bits unchanged. BW=0 is a no-op.
- Read: CEN_A=1, idle: Q <= mem[{AW_A,AC_A}]. With CEN_A=0, Q holds its value.
- Read/write to the same address in the same cycle: write-first. Q returns the merged word, (old & ~BW) | (D & BW).
- DEEPSLEEP=1: both ports are ignored, Q holds, and contents are retained.
- POWERGATE=1 (priority over DEEPSLEEP): ports are ignored, Q <= 0, and every word is cleared to 0 on each cycle it is asserted.
- "Idle" means DEEPSLEEP=0 and POWERGATE=0.
- RST=1: Q, OBSV_DBW, OBSV_CTL_A and OBSV_CTL_B go to 0. Array contents are not cleared. A write presented in a reset cycle is discarded.
- OBSV_DBW <= BW & {DATA_WIDTH{CEN_B & idle}}, updated every cycle.

## Timing
- Read latency is 1 cycle: address at edge N gives Q valid after edge N+1 and stable until the next accepted read.
- A write at edge N is visible to a read issued at edge N (write-first) and at any later edge.
- The OBSV_* outputs lag their inputs by 1 cycle.
- Reset takes effect at the clock edge. Outputs read 0 from the first cycle after that edge until the first accepted read after RST falls.

## Configuration
- Macro: R2PV_TEST_BYPASS_EN.
- When defined, T_LOGIC=1 with CEN_A=1 makes Q <= D (a registered bypass that does not touch the array), and writes are suppressed.
- When undefined, T_LOGIC is ignored and the bypass logic is not synthesized.

## Structure
- Package r2pv_pkg holds:
  - the size constants for each variant (128x26, 128x64, 256x26);
  - the AC width constant (2);
  - the observation-bus widths.
- Sub-module r2pv_array holds the storage, with masked write and write-first read merge. The top level holds the power/sleep gating, the Q register, the OBSV registers and the bypass.

## Test plan
- Basic read: reset, write 0x2AAAAAA at addr 5 with BW all-ones, read addr 5 next cycle → Q = 0x2AAAAAA one cycle after the read.
- Masked write: write 0x3FFFFFF then 0x0000000 to addr 127 with BW = 0x00000FF, read → Q = 0x3FFFF00.
- Same-cycle collision: addr 9 holds 0x1234567; write 0x0ABCDEF with BW all-ones and read addr 9 in the same cycle → Q = 0x0ABCDEF.
- DEEPSLEEP retention: write 0x155 to addr 0, assert DEEPSLEEP, attempt write 0x0 and read → Q unchanged. Deassert DEEPSLEEP and read → Q = 0x155.
- POWERGATE clear: assert POWERGATE one cycle → Q = 0. Read addr 0 afterwards → Q = 0.
- Reset mid-read: issue read of a nonzero word with RST=1 in the same cycle → Q = 0 and OBSV_CTL_A = 0. The next read after RST falls returns the stored word, unchanged.

Source files
------------

// File: rtl/r2pv_pkg.sv
// r2pv_pkg: shared constants and types for the r2pv two-port SRAM macro model.
//   - size constants for the 128x26, 128x64 and 256x26 variants
//   - column-address (AC) width and observation-bus widths
//   - power-mode decode used by the top-level gating
package r2pv_pkg;

  localparam int unsigned R2PV_128X26_WORDS = 128;
  localparam int unsigned R2PV_128X26_WIDTH = 26;
  localparam int unsigned R2PV_128X64_WORDS = 128;
  localparam int unsigned R2PV_128X64_WIDTH = 64;
  localparam int unsigned R2PV_256X26_WORDS = 256;
  localparam int unsigned R2PV_256X26_WIDTH = 26;

  localparam int unsigned AC_WIDTH       = 2;
  localparam int unsigned OBSV_CTL_WIDTH = 2;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'd0,
    PWR_SLEEP  = 2'd1,
    PWR_GATED  = 2'd2
  } pwr_mode_e;

  // Power-gate dominates retention sleep.
  function automatic pwr_mode_e pwr_mode(input logic powergate, input logic deepsleep);
    if (powergate) return PWR_GATED;
    if (deepsleep) return PWR_SLEEP;
    return PWR_ACTIVE;
  endfunction

endpackage

// File: rtl/r2pv_array.sv
// r2pv_array: storage core with bit-masked write and write-first read merge.
//   clk      in   clock
//   clear    in   clear every word to 0 this cycle (power-gate)
//   we       in   masked write enable (already qualified by the top level)
//   waddr    in   write word index
//   d / bw   in   write data / per-bit write mask (1 = write)
//   raddr    in   read word index
//   rdata_c  out  combinational read word, merged with a same-cycle write
module r2pv_array
  import r2pv_pkg::*;
#(
  parameter int unsigned WORDS      = R2PV_128X26_WORDS,
  parameter int unsigned DATA_WIDTH = R2PV_128X26_WIDTH,
  localparam int unsigned ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] bw,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata_c
);

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] wmerged_c;

  // Word as it will look after this cycle's masked write.
  assign wmerged_c = (mem[waddr] & ~bw) | (d & bw);

  // Write-first: a read hitting the word being written sees the merged value.
  assign rdata_c = (we && (raddr == waddr)) ? wmerged_c : mem[raddr];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wmerged_c;
    end
  end

endmodule

// File: rtl/r2pv_128x26.sv
// r2pv_128x26: two-port (1R/1W) synchronous SRAM macro model, 128 x 26 default.
//   CLK, RST            clock; synchronous active-high reset (array not cleared)
//   CEN_A, AW_A, AC_A   read enable / row / column address; Q registered read data
//   CEN_B, AW_B, AC_B   write enable / row / column address; D data, BW bit mask
//   T_LOGIC             logic-test bypass (only with R2PV_TEST_BYPASS_EN)
//   POWERGATE           ports ignored, Q and every word cleared while asserted
//   DEEPSLEEP           ports ignored, Q and contents retained
//   MA_*                margin adjust, no functional effect
//   OBSV_DBW            registered effective write mask
//   OBSV_CTL_A/B        registered {MA_TPx, CEN_x}
// Optional feature macro: R2PV_TEST_BYPASS_EN (T_LOGIC & CEN_A gives Q <= D,
// writes suppressed while T_LOGIC is high).
module r2pv_128x26
  import r2pv_pkg::*;
#(
  parameter int unsigned WORDS      = R2PV_128X26_WORDS,
  parameter int unsigned DATA_WIDTH = R2PV_128X26_WIDTH,
  localparam int unsigned AW_WIDTH  = $clog2(WORDS) - AC_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CEN_A,
  input  logic [AW_WIDTH-1:0]       AW_A,
  input  logic [AC_WIDTH-1:0]       AC_A,
  output logic [DATA_WIDTH-1:0]     Q,
  input  logic                      CEN_B,
  input  logic [AW_WIDTH-1:0]       AW_B,
  input  logic [AC_WIDTH-1:0]       AC_B,
  input  logic [DATA_WIDTH-1:0]     D,
  input  logic [DATA_WIDTH-1:0]     BW,
  input  logic                      T_LOGIC,
  input  logic                      POWERGATE,
  input  logic                      DEEPSLEEP,
  input  logic                      MA_SAWL,
  input  logic                      MA_TPA,
  input  logic                      MA_TPB,
  input  logic                      MA_WL,
  input  logic                      MA_WRAS,
  input  logic                      MA_WRASD,
  output logic [DATA_WIDTH-1:0]     OBSV_DBW,
  output logic [OBSV_CTL_WIDTH-1:0] OBSV_CTL_A,
  output logic [OBSV_CTL_WIDTH-1:0] OBSV_CTL_B
);

  localparam int unsigned ADDR_WIDTH = AW_WIDTH + AC_WIDTH;

  pwr_mode_e             mode_c;
  logic                  idle_c;
  logic                  clear_c;
  logic                  bypass_c;
  logic                  test_mode_c;
  logic                  we_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  unused_inputs;

  assign mode_c  = pwr_mode(POWERGATE, DEEPSLEEP);
  assign idle_c  = (mode_c == PWR_ACTIVE);
  assign clear_c = (mode_c == PWR_GATED);

`ifdef R2PV_TEST_BYPASS_EN
  assign bypass_c      = T_LOGIC & CEN_A;
  assign test_mode_c   = T_LOGIC;
  assign unused_inputs = ^{MA_SAWL, MA_WL, MA_WRAS, MA_WRASD};
`else
  assign bypass_c      = 1'b0;
  assign test_mode_c   = 1'b0;
  assign unused_inputs = ^{MA_SAWL, MA_WL, MA_WRAS, MA_WRASD, T_LOGIC};
`endif

  // Writes in a reset cycle or in test mode never reach the array.
  assign we_c = CEN_B & idle_c & ~RST & ~test_mode_c;

  r2pv_array #(
    .WORDS      (WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (CLK),
    .clear   (clear_c),
    .we      (we_c),
    .waddr   (ADDR_WIDTH'({AW_B, AC_B})),
    .d       (D),
    .bw      (BW),
    .raddr   (ADDR_WIDTH'({AW_A, AC_A})),
    .rdata_c (rdata_c)
  );

  // Read data register: holds unless a read is accepted or power-gate clears it.
  always_ff @(posedge CLK) begin
    if (RST || clear_c) begin
      Q <= '0;
    end else if (idle_c && CEN_A) begin
      Q <= bypass_c ? D : rdata_c;
    end
  end

  // Observation registers, sampled every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OBSV_DBW   <= '0;
      OBSV_CTL_A <= '0;
      OBSV_CTL_B <= '0;
    end else begin
      OBSV_DBW   <= BW & {DATA_WIDTH{CEN_B & idle_c}};
      OBSV_CTL_A <= {MA_TPA, CEN_A};
      OBSV_CTL_B <= {MA_TPB, CEN_B};
    end
  end

endmodule

// File: tb/tb_r2pv_128x26.sv
module tb_r2pv_128x26;

  logic        CLK = 1'b0;
  logic        RST, CEN_A, CEN_B, T_LOGIC, POWERGATE, DEEPSLEEP;
  logic        MA_SAWL, MA_TPA, MA_TPB, MA_WL, MA_WRAS, MA_WRASD;
  logic [4:0]  AW_A, AW_B;
  logic [1:0]  AC_A, AC_B;
  logic [25:0] D, BW, Q, OBSV_DBW;
  logic [1:0]  OBSV_CTL_A, OBSV_CTL_B;

  int checks = 0;
  int errors = 0;

  localparam logic [25:0] ONES = 26'h3FFFFFF;

  r2pv_128x26 dut (
    .CLK(CLK), .RST(RST),
    .CEN_A(CEN_A), .AW_A(AW_A), .AC_A(AC_A), .Q(Q),
    .CEN_B(CEN_B), .AW_B(AW_B), .AC_B(AC_B), .D(D), .BW(BW),
    .T_LOGIC(T_LOGIC), .POWERGATE(POWERGATE), .DEEPSLEEP(DEEPSLEEP),
    .MA_SAWL(MA_SAWL), .MA_TPA(MA_TPA), .MA_TPB(MA_TPB), .MA_WL(MA_WL),
    .MA_WRAS(MA_WRAS), .MA_WRASD(MA_WRASD),
    .OBSV_DBW(OBSV_DBW), .OBSV_CTL_A(OBSV_CTL_A), .OBSV_CTL_B(OBSV_CTL_B)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet;
    CEN_A = 0; CEN_B = 0; T_LOGIC = 0; POWERGATE = 0; DEEPSLEEP = 0;
    MA_SAWL = 0; MA_TPA = 0; MA_TPB = 0; MA_WL = 0; MA_WRAS = 0; MA_WRASD = 0;
    D = '0; BW = '0;
  endtask

  task automatic set_rd(input logic en, input int addr);
    logic [6:0] a;
    a = 7'(addr);
    CEN_A = en; AW_A = a[6:2]; AC_A = a[1:0];
  endtask

  task automatic set_wr(input logic en, input int addr, input logic [25:0] data,
                        input logic [25:0] mask);
    logic [6:0] a;
    a = 7'(addr);
    CEN_B = en; AW_B = a[6:2]; AC_B = a[1:0]; D = data; BW = mask;
  endtask

  task automatic test_reset;
    quiet(); set_rd(0, 0); set_wr(0, 0, '0, '0);
    RST = 1; tick(); tick();
    checks++; if (Q !== 26'h0) begin errors++; $display("FAIL reset_q got %h want %h", Q, 26'h0); end
    checks++; if (OBSV_DBW !== 26'h0) begin errors++; $display("FAIL reset_dbw got %h want %h", OBSV_DBW, 26'h0); end
    checks++; if (OBSV_CTL_A !== 2'b00 || OBSV_CTL_B !== 2'b00) begin errors++;
      $display("FAIL reset_ctl got %b/%b want 00/00", OBSV_CTL_A, OBSV_CTL_B); end
    RST = 0;
  endtask

  task automatic test_basic_read;
    set_wr(1, 5, 26'h2AAAAAA, ONES); MA_TPB = 1; tick();
    checks++; if (OBSV_DBW !== ONES) begin errors++; $display("FAIL basic_dbw got %h want %h", OBSV_DBW, ONES); end
    checks++; if (OBSV_CTL_B !== 2'b11) begin errors++; $display("FAIL basic_ctl_b got %b want 11", OBSV_CTL_B); end
    set_wr(0, 5, '0, '0); MA_TPB = 0; set_rd(1, 5); tick();
    checks++; if (Q !== 26'h2AAAAAA) begin errors++; $display("FAIL basic_read got %h want %h", Q, 26'h2AAAAAA); end
    checks++; if (OBSV_CTL_A !== 2'b01) begin errors++; $display("FAIL basic_ctl_a got %b want 01", OBSV_CTL_A); end
    set_rd(0, 6); tick();
    checks++; if (Q !== 26'h2AAAAAA) begin errors++; $display("FAIL basic_hold got %h want %h", Q, 26'h2AAAAAA); end
  endtask

  task automatic test_masked_write;
    set_wr(1, 127, ONES, ONES); tick();
    set_wr(1, 127, 26'h0, 26'h00000FF); tick();
    set_wr(0, 127, '0, '0); set_rd(1, 127); tick();
    checks++; if (Q !== 26'h3FFFF00) begin errors++; $display("FAIL masked_write got %h want %h", Q, 26'h3FFFF00); end
    set_rd(0, 0); set_wr(1, 127, 26'h0, 26'h0); tick();
    checks++; if (OBSV_DBW !== 26'h0) begin errors++; $display("FAIL masked_dbw0 got %h want %h", OBSV_DBW, 26'h0); end
    set_wr(0, 127, '0, '0); set_rd(1, 127); tick();
    checks++; if (Q !== 26'h3FFFF00) begin errors++; $display("FAIL masked_noop got %h want %h", Q, 26'h3FFFF00); end
    set_rd(0, 0);
  endtask

  task automatic test_collision;
    set_wr(1, 9, 26'h1234567, ONES); tick();
    set_wr(1, 9, 26'h0ABCDEF, ONES); set_rd(1, 9); tick();
    checks++; if (Q !== 26'h0ABCDEF) begin errors++; $display("FAIL collision_full got %h want %h", Q, 26'h0ABCDEF); end
    // old 0x0ABCDEF, upper six bits taken from D
    set_wr(1, 9, ONES, 26'h3F00000); set_rd(1, 9); tick();
    checks++; if (Q !== 26'h3FBCDEF) begin errors++; $display("FAIL collision_masked got %h want %h", Q, 26'h3FBCDEF); end
    set_wr(0, 9, '0, '0); set_rd(0, 0);
  endtask

  task automatic test_deepsleep;
    set_wr(1, 0, 26'h155, ONES); tick();
    set_wr(1, 0, 26'h0, ONES); set_rd(1, 0); DEEPSLEEP = 1; tick();
    checks++; if (Q !== 26'h3FBCDEF) begin errors++; $display("FAIL sleep_q_hold got %h want %h", Q, 26'h3FBCDEF); end
    checks++; if (OBSV_DBW !== 26'h0) begin errors++; $display("FAIL sleep_dbw got %h want %h", OBSV_DBW, 26'h0); end
    set_wr(0, 0, '0, '0); DEEPSLEEP = 0; tick();
    checks++; if (Q !== 26'h155) begin errors++; $display("FAIL sleep_retain got %h want %h", Q, 26'h155); end
    set_rd(0, 0);
  endtask

  task automatic test_powergate;
    POWERGATE = 1; DEEPSLEEP = 1; tick();
    checks++; if (Q !== 26'h0) begin errors++; $display("FAIL pg_q got %h want %h", Q, 26'h0); end
    POWERGATE = 0; DEEPSLEEP = 0; set_rd(1, 0); tick();
    checks++; if (Q !== 26'h0) begin errors++; $display("FAIL pg_word0 got %h want %h", Q, 26'h0); end
    set_rd(1, 127); tick();
    checks++; if (Q !== 26'h0) begin errors++; $display("FAIL pg_word127 got %h want %h", Q, 26'h0); end
    set_rd(0, 0);
  endtask

  task automatic test_reset_mid_read;
    set_wr(1, 20, 26'h1555555, ONES); tick();
    set_wr(0, 20, '0, '0); set_rd(1, 20); tick();
    set_wr(1, 20, 26'h0, ONES); set_rd(1, 20); MA_TPA = 1; RST = 1; tick();
    checks++; if (Q !== 26'h0) begin errors++; $display("FAIL rst_read_q got %h want %h", Q, 26'h0); end
    checks++; if (OBSV_CTL_A !== 2'b00) begin errors++; $display("FAIL rst_ctl_a got %b want 00", OBSV_CTL_A); end
    RST = 0; set_wr(0, 20, '0, '0); set_rd(0, 20); MA_TPA = 0; tick();
    checks++; if (Q !== 26'h0) begin errors++; $display("FAIL rst_q_stays0 got %h want %h", Q, 26'h0); end
    set_rd(1, 20); MA_TPA = 1; tick();
    checks++; if (Q !== 26'h1555555) begin errors++; $display("FAIL rst_retained got %h want %h", Q, 26'h1555555); end
    checks++; if (OBSV_CTL_A !== 2'b11) begin errors++; $display("FAIL rst_ctl_a_after got %b want 11", OBSV_CTL_A); end
    set_rd(0, 0); MA_TPA = 0;
  endtask

  task automatic test_t_logic;
    set_wr(1, 20, 26'h0000ABC, ONES); set_rd(1, 20); T_LOGIC = 1; tick();
`ifdef R2PV_TEST_BYPASS_EN
    checks++; if (Q !== 26'h0000ABC) begin errors++; $display("FAIL bypass_q got %h want %h", Q, 26'h0000ABC); end
`else
    checks++; if (Q !== 26'h0000ABC) begin errors++; $display("FAIL tlogic_ignored_q got %h want %h", Q, 26'h0000ABC); end
`endif
    T_LOGIC = 0; set_wr(0, 20, '0, '0); D = 26'h1; tick();
`ifdef R2PV_TEST_BYPASS_EN
    checks++; if (Q !== 26'h1555555) begin errors++; $display("FAIL bypass_no_write got %h want %h", Q, 26'h1555555); end
`else
    checks++; if (Q !== 26'h0000ABC) begin errors++; $display("FAIL tlogic_write got %h want %h", Q, 26'h0000ABC); end
`endif
    set_rd(0, 0);
  endtask

  initial begin
    RST = 1; quiet(); set_rd(0, 0); set_wr(0, 0, '0, '0);
    test_reset();
    test_basic_read();
    test_masked_write();
    test_collision();
    test_deepsleep();
    test_powergate();
    test_reset_mid_read();
    test_t_logic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
